// File: rtl/usb_multi_ep_protocol_controller.sv
// Bulk-transfer protocol FSM for NUM_EP endpoints sharing one data buffer.
// Tracks DATA0/DATA1 per endpoint, retries IN on ACK timeout, discards bad OUT data.
// Optional feature macro: USB_EP_STALL_EN (per-endpoint halt with STALL handshake).
module usb_multi_ep_protocol_controller #(
    parameter int NUM_EP      = 4,
    parameter int OCC_W       = 7,
    parameter int TIMEOUT_CYC = 128,
    localparam int EP_W       = $clog2(NUM_EP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        RX_Packet,
    input  logic [EP_W-1:0]   RX_Endpoint,
    input  logic              RX_Toggle,
    input  logic [OCC_W-1:0]  Buffer_Occupancy,
    input  logic [OCC_W-1:0]  TX_Packet_Data_Size,
    input  logic              Buffer_Reserved,
    input  logic [EP_W-1:0]   Reserved_EP,
    input  logic              TX_Done,
    output logic [2:0]        TX_Packet,
    output logic              RX_Transfer_Active,
    output logic              TX_Transfer_Active,
    output logic              RX_Data_Ready,
    output logic              RX_Error,
    output logic              TX_Error,
    output logic              D_Mode,
    output logic              clear,
    output logic [EP_W-1:0]   Active_EP,
`ifdef USB_EP_STALL_EN
    input  logic [NUM_EP-1:0] Stall_Set,
    input  logic [NUM_EP-1:0] Stall_Clr,
    output logic [NUM_EP-1:0] EP_Halted,
`endif
    output logic [NUM_EP-1:0] EP_Toggle
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] RX_IN   = 3'b001;
    localparam logic [2:0] RX_OUT  = 3'b010;
    localparam logic [2:0] RX_ACK  = 3'b011;
    localparam logic [2:0] RX_NAK  = 3'b100;
    localparam logic [2:0] RX_DOK  = 3'b101;
    localparam logic [2:0] RX_DERR = 3'b110;

    localparam logic [2:0] TX_NONE  = 3'b000;
    localparam logic [2:0] TX_DATA0 = 3'b001;
    localparam logic [2:0] TX_DATA1 = 3'b010;
    localparam logic [2:0] TX_ACK   = 3'b011;
    localparam logic [2:0] TX_NAK   = 3'b100;
`ifdef USB_EP_STALL_EN
    localparam logic [2:0] TX_STALL = 3'b101;
`endif

    typedef enum logic [3:0] {
        ST_IDLE, ST_OUT_RX, ST_OUT_ACK, ST_OUT_DUP, ST_OUT_NAK,
        ST_IN_TX, ST_IN_WAIT, ST_IN_NAK
`ifdef USB_EP_STALL_EN
        , ST_STALL
`endif
    } state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic [EP_W-1:0]   ep_n;
    logic [NUM_EP-1:0] toggle_n;
    logic [2:0]        tx_pkt_n;
    logic              rx_act_n, tx_act_n, rdy_n, rx_err_n, tx_err_n, dmode_n, clear_n;
    logic              token, in_ready;
`ifdef USB_EP_STALL_EN
    logic [NUM_EP-1:0] halted_n;
`endif

    // Next state, toggle/timer updates and next registered output values.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        ep_n     = Active_EP;
        toggle_n = EP_Toggle;
        rdy_n    = 1'b0;
        rx_err_n = 1'b0;
        tx_err_n = 1'b0;
        clear_n  = 1'b0;
        tx_pkt_n = TX_NONE;
        rx_act_n = 1'b0;
        tx_act_n = 1'b0;
        dmode_n  = 1'b0;
        token    = (RX_Packet == RX_IN) || (RX_Packet == RX_OUT);
        in_ready = Buffer_Reserved && (Reserved_EP == RX_Endpoint) &&
                   (Buffer_Occupancy == TX_Packet_Data_Size) && (TX_Packet_Data_Size != '0);

        case (state)
            ST_IDLE: begin
                if (token) begin
                    ep_n = RX_Endpoint;
`ifdef USB_EP_STALL_EN
                    if (EP_Halted[RX_Endpoint]) state_n = ST_STALL;
                    else
`endif
                    if (RX_Packet == RX_OUT) begin
                        if (Buffer_Occupancy == '0 && !Buffer_Reserved) begin
                            state_n = ST_OUT_RX;
                        end else begin
                            state_n  = ST_OUT_NAK;
                            rx_err_n = 1'b1;
                        end
                    end else if (in_ready) begin
                        state_n = ST_IN_TX;
                    end else begin
                        state_n  = ST_IN_NAK;
                        tx_err_n = 1'b1;
                    end
                end
            end
            ST_OUT_RX: begin
                if (RX_Packet == RX_DOK) begin
                    if (RX_Toggle == EP_Toggle[Active_EP]) begin
                        state_n             = ST_OUT_ACK;
                        toggle_n[Active_EP] = ~EP_Toggle[Active_EP];
                        rdy_n               = 1'b1;
                    end else begin
                        // Host retry of data already accepted: ACK it but drop the copy.
                        state_n = ST_OUT_DUP;
                        clear_n = 1'b1;
                    end
                end else if (RX_Packet == RX_DERR || token) begin
                    state_n  = ST_IDLE;
                    clear_n  = 1'b1;
                    rx_err_n = 1'b1;
                end
            end
            ST_IN_TX: begin
                if (TX_Done) begin
                    state_n = ST_IN_WAIT;
                    timer_n = '0;
                end
            end
            ST_IN_WAIT: begin
                if (RX_Packet == RX_ACK) begin
                    state_n             = ST_IDLE;
                    clear_n             = 1'b1;
                    toggle_n[Active_EP] = ~EP_Toggle[Active_EP];
                end else if (RX_Packet == RX_NAK || token || timer == TMR_LAST) begin
                    state_n  = ST_IDLE;
                    tx_err_n = 1'b1;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            default: begin
                // Handshake-sending states: only TX_Done matters, RX packets are dropped.
                if (TX_Done) state_n = ST_IDLE;
            end
        endcase

`ifdef USB_EP_STALL_EN
        halted_n = (EP_Halted & ~Stall_Clr) | Stall_Set;
        toggle_n = toggle_n & ~(Stall_Clr & ~Stall_Set);
`endif

        // Level outputs follow the state being entered so they register with it.
        case (state_n)
            ST_OUT_RX: begin
                rx_act_n = 1'b1;
                dmode_n  = 1'b1;
            end
            ST_OUT_ACK, ST_OUT_DUP: begin
                tx_pkt_n = TX_ACK;
                dmode_n  = 1'b1;
            end
            ST_OUT_NAK, ST_IN_NAK: tx_pkt_n = TX_NAK;
            ST_IN_TX: begin
                tx_act_n = 1'b1;
                tx_pkt_n = toggle_n[ep_n] ? TX_DATA1 : TX_DATA0;
            end
            ST_IN_WAIT: tx_act_n = 1'b1;
`ifdef USB_EP_STALL_EN
            ST_STALL: tx_pkt_n = TX_STALL;
`endif
            default: tx_pkt_n = TX_NONE;
        endcase
    end

    // State, per-endpoint bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            timer              <= '0;
            Active_EP          <= '0;
            EP_Toggle          <= '0;
            TX_Packet          <= TX_NONE;
            RX_Transfer_Active <= 1'b0;
            TX_Transfer_Active <= 1'b0;
            RX_Data_Ready      <= 1'b0;
            RX_Error           <= 1'b0;
            TX_Error           <= 1'b0;
            D_Mode             <= 1'b0;
            clear              <= 1'b0;
`ifdef USB_EP_STALL_EN
            EP_Halted          <= '0;
`endif
        end else begin
            state              <= state_n;
            timer              <= timer_n;
            Active_EP          <= ep_n;
            EP_Toggle          <= toggle_n;
            TX_Packet          <= tx_pkt_n;
            RX_Transfer_Active <= rx_act_n;
            TX_Transfer_Active <= tx_act_n;
            RX_Data_Ready      <= rdy_n;
            RX_Error           <= rx_err_n;
            TX_Error           <= tx_err_n;
            D_Mode             <= dmode_n;
            clear              <= clear_n;
`ifdef USB_EP_STALL_EN
            EP_Halted          <= halted_n;
`endif
        end
    end

endmodule
